// File: rtl/fas_pkg.sv
// Shared types and helpers for the FAS symmetric FIR.
package fas_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } fir_state_t;

    // Rounding modes understood by fas_round_sat.
    localparam int RND_NEAREST_AWAY = 0;   // round half away from zero
    localparam int RND_TRUNC        = 1;   // floor (drop fraction)

    // Accumulator width that cannot overflow for taps/2 pre-added products.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + 1 + coef_w + $clog2(taps / 2);
    endfunction

endpackage

// File: rtl/fas_round_sat.sv
// Combinational accumulator -> sample narrowing for the FAS FIR.
// Drops FRAC fraction bits with the selected rounding mode, then narrows to DATA_W.
// Build option FAS_FIR_SAT_EN: defined -> clamp to the DATA_W range;
// undefined -> legacy FAS wrap format {acc sign, low DATA_W-1 bits}.
module fas_round_sat
    import fas_pkg::*;
#(
    parameter int ACC_W  = 41,
    parameter int DATA_W = 16,
    parameter int FRAC   = 16,
    parameter int MODE   = RND_NEAREST_AWAY
) (
    input  logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] data
);

    // One extra integer bit so the +1 of rounding can never overflow.
    localparam int RW = ACC_W - FRAC + 1;

    logic          sign;
    logic          tail;
    logic          inc;
    logic [RW-1:0] trunc;
    logic [RW-1:0] rnd;

    assign sign  = acc[ACC_W-1];
    assign tail  = |acc[FRAC-2:0];
    assign trunc = {sign, acc[ACC_W-1:FRAC]};

    // Half bit decides; a negative exact half stays at floor, i.e. away from zero.
    always_comb begin
        inc = 1'b0;
        if (MODE == RND_NEAREST_AWAY)
            inc = sign ? (acc[FRAC-1] && tail) : acc[FRAC-1];
    end

    assign rnd = trunc + RW'(inc);

`ifdef FAS_FIR_SAT_EN
    localparam logic [RW-1:0] MAXV = {{(RW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic [RW-1:0] MINV = {{(RW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Clamp the rounded value into the signed DATA_W range.
    always_comb begin
        data = rnd[DATA_W-1:0];
        if ($signed(rnd) > $signed(MAXV))
            data = MAXV[DATA_W-1:0];
        else if ($signed(rnd) < $signed(MINV))
            data = MINV[DATA_W-1:0];
    end
`else
    // Legacy format keeps the accumulator sign and discards rounded upper bits.
    logic unused_hi;
    assign unused_hi = ^rnd[RW-1:DATA_W-1];
    assign data      = {sign, rnd[DATA_W-2:0]};
`endif

endmodule

// File: rtl/fas_fir_stream.sv
// Time-multiplexed, runtime-programmable symmetric FIR with valid/ready streaming.
// One multiplier walks TAPS/2 coefficient pairs per sample; the product is
// registered, so MAC takes TAPS/2+1 cycles (last one drains the product).
// out_last flags every FRAME_LEN-th output. Build option FAS_FIR_SAT_EN
// selects saturating narrowing (see fas_round_sat).
module fas_fir_stream
    import fas_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 20,
    parameter int FRAC      = 16,
    parameter int TAPS      = 32,
    parameter int FRAME_LEN = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS/2)-1:0] coef_addr,
    input  logic [COEF_W-1:0]         coef_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output logic                      busy
);

    localparam int HALF  = TAPS / 2;
    localparam int KW    = $clog2(HALF);
    localparam int CW    = $clog2(HALF + 1);
    localparam int XW    = $clog2(TAPS);
    localparam int SW    = $clog2(TAPS + 1);
    localparam int FW    = $clog2(FRAME_LEN);
    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
    localparam int PW    = DATA_W + 1 + COEF_W;

    fir_state_t state, state_nxt;

    logic [DATA_W-1:0] x    [TAPS];
    logic [COEF_W-1:0] coef [HALF];
    logic [CW-1:0]     k;
    logic [SW-1:0]     sample_cnt;
    logic [FW-1:0]     frame_cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [PW-1:0]     prod_q;
    logic [PW-1:0]     prod;
    logic [PW-1:0]     pair_ext;
    logic [PW-1:0]     coef_ext;
    logic [DATA_W:0]   pair;
    logic [KW-1:0]     k_idx;
    logic [XW-1:0]     lo_idx;
    logic [XW-1:0]     hi_idx;
    logic [DATA_W-1:0] rounded;
    logic              accept;
    logic              mac_done;
    logic              frame_full;

    assign k_idx      = k[KW-1:0];
    assign lo_idx     = XW'(k_idx);
    assign hi_idx     = XW'(TAPS - 1) - XW'(k_idx);
    assign accept     = in_valid && in_ready;
    assign mac_done   = (state == MAC) && (k == CW'(HALF));
    assign frame_full = (sample_cnt == SW'(TAPS));

    // Symmetric pre-add, then one signed multiply at full product width.
    assign pair     = {x[lo_idx][DATA_W-1], x[lo_idx]} + {x[hi_idx][DATA_W-1], x[hi_idx]};
    assign pair_ext = {{(PW-DATA_W-1){pair[DATA_W]}}, pair};
    assign coef_ext = {{(PW-COEF_W){coef[k_idx][COEF_W-1]}}, coef[k_idx]};
    assign prod     = PW'($signed(pair_ext) * $signed(coef_ext));
    assign acc_sum  = acc + {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};

    fas_round_sat #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC   (FRAC),
        .MODE   (RND_NEAREST_AWAY)
    ) u_round (
        .acc  (acc_sum),
        .data (rounded)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = MAC;
            end
            MAC: begin
                if (mac_done) state_nxt = frame_full ? OUT : IDLE;
            end
            OUT: begin
                out_valid = 1'b1;
                out_last  = (frame_cnt == FW'(FRAME_LEN - 1));
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Delay line, coefficient store, MAC datapath and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) x[i] <= '0;
            for (int i = 0; i < HALF; i++) coef[i] <= '0;
            k          <= '0;
            sample_cnt <= '0;
            frame_cnt  <= '0;
            acc        <= '0;
            prod_q     <= '0;
            out_data   <= '0;
        end else begin
            if (accept) begin
                x[0] <= in_data;
                for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
                if (!frame_full) sample_cnt <= sample_cnt + SW'(1);
                acc    <= '0;
                prod_q <= '0;
                k      <= '0;
            end
            if (state == MAC) begin
                acc    <= acc_sum;
                prod_q <= mac_done ? '0 : prod;
                k      <= k + CW'(1);
                if (mac_done && frame_full) out_data <= rounded;
            end
            if (state == OUT && out_ready) frame_cnt <= frame_cnt + FW'(1);
            if (coef_we && state == IDLE) coef[coef_addr] <= coef_data;
        end
    end

endmodule

// File: tb/tb_fas_fir_stream.sv
// Directed self-checking bench for fas_fir_stream (default parameters).
module tb_fas_fir_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [19:0] coef_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int ov_seen = 0;

`ifdef FAS_FIR_SAT_EN
    localparam int SAT_EXP = 32767;
`else
    localparam int SAT_EXP = 32751;  // 0x7FEF: sign 0, low 15 bits of 524271
`endif

    fas_fir_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (out_valid) ov_seen <= ov_seen + 1;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr_coef(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = a[3:0];
        coef_data = d[19:0];
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic push(input int s);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = s[15:0];
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_out(input string tag, input int exp_d, input int exp_l);
        int n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            chk({tag, "_data"}, $signed(out_data), exp_d);
            chk({tag, "_last"}, {31'd0, out_last}, exp_l);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int base;
        int cyc;
        int stab;

        // Reset state
        do_reset();
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", $signed(out_data), 0);
        chk("rst_out_last", {31'd0, out_last}, 0);
        chk("rst_busy", {31'd0, busy}, 0);

        // Impulse on c[0] with warm-up: 31 samples give no output
        wr_coef(0, 'h10000);
        base = ov_seen;
        for (int i = 1; i <= 31; i++) push(i);
        repeat (20) @(negedge clk);
        chk("warmup_no_out", ov_seen - base, 0);

        // 32nd sample: latency and first value x[0]+x[31] = 32+1
        push(32);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, 17);
        chk("imp_data", $signed(out_data), 33);
        chk("imp_last", {31'd0, out_last}, 0);
        chk("out_in_ready", {31'd0, in_ready}, 0);
        chk("out_busy", {31'd0, busy}, 1);

        // Backpressure: output held, offered sample not taken meanwhile
        in_valid = 1'b1;
        in_data  = 16'd33;
        stab = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_data === 16'd33 && out_last === 1'b0 && in_ready === 1'b0)
                stab++;
        end
        chk("bp_hold_cycles", stab, 10);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_ready", {31'd0, in_ready}, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_accept_busy", {31'd0, busy}, 1);
        get_out("bp_next", 35, 0);

        // Framing: output m = n-31 has value 2n-31; last on outputs 16 and 32
        for (int n = 34; n <= 63; n++) begin
            push(n);
            get_out($sformatf("frame%0d", n), 2 * n - 31, (n == 47 || n == 63) ? 1 : 0);
        end

        // Several coefficients incl. negative: c0=1, c1=2, c15=-1, all pairs 33
        do_reset();
        wr_coef(0, 'h10000);
        wr_coef(1, 'h20000);
        wr_coef(15, 'hF0000);
        for (int i = 1; i <= 32; i++) push(i);
        get_out("mixed", 66, 0);

        // Coefficient write while busy must be dropped
        push(33);
        repeat (2) @(negedge clk);
        chk("busy_in_mac", {31'd0, busy}, 1);
        wr_coef(0, 0);
        get_out("mixed2", 70, 0);
        push(34);
        get_out("busy_drop", 74, 0);

        // Reset mid-MAC: nothing comes out, everything cleared
        push(35);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rmac_busy", {31'd0, busy}, 0);
        chk("rmac_out_valid", {31'd0, out_valid}, 0);
        chk("rmac_in_ready", {31'd0, in_ready}, 1);
        chk("rmac_out_data", $signed(out_data), 0);
        base = ov_seen;
        repeat (25) @(negedge clk);
        chk("rmac_no_out", ov_seen - base, 0);

        // Coefficients cleared by reset: full window of 5s filters to 0
        base = ov_seen;
        for (int i = 0; i < 31; i++) push(5);
        repeat (20) @(negedge clk);
        chk("rmac_warmup", ov_seen - base, 0);
        push(5);
        get_out("coef_cleared", 0, 0);

        // Rounding with c0 = 0.5: pairs 3,-3,1,-1 -> 2,-2,1,-1
        do_reset();
        wr_coef(0, 'h8000);
        for (int i = 0; i < 31; i++) push(0);
        push(3);
        get_out("rnd_p3", 2, 0);
        push(-3);
        get_out("rnd_m3", -2, 0);
        push(1);
        get_out("rnd_p1", 1, 0);
        push(-1);
        get_out("rnd_m1", -1, 0);

        // Narrowing of an out-of-range result
        do_reset();
        wr_coef(0, 'h7FFFF);
        for (int i = 0; i < 32; i++) push('h7FFF);
        get_out("sat", SAT_EXP, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
